uart_cfg: RTL and testbench

UART_CFG -- requirements
Module: uart_cfg

---
 rtl/uart_cfg.sv | 180 ++++++++++++++++++
 tb/tb_uart_cfg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: configurable UART (parity, 1/2 stop bits, internal loopback) with shared oversampling baud generator
module uart_cfg #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     dvsr,
    input  logic            cfg_par_en,
    input  logic            cfg_par_odd,
    input  logic            cfg_stop2,
    input  logic            cfg_loopback,
    input  logic [DBIT-1:0] din,
    input  logic            tx_start,
    input  logic            rx,
    output logic            tx,
    output logic            tx_busy,
    output logic            rx_busy,
    output logic            tx_done_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [4:0] LAST  = 5'(SB_TICK - 1);
    localparam logic [4:0] HALF  = 5'(SB_TICK / 2 - 1);
    localparam logic [3:0] NLAST = 4'(DBIT - 1);
    logic [10:0] cnt, dvsr_q;
    logic s_tick;
    state_t tx_state, rx_state;
    logic [4:0] tx_s, rx_s;
    logic [3:0] tx_n, rx_n;
    logic [DBIT-1:0] tx_b, rx_b;
    logic tx_q, tx_par, tx_pe, tx_st2, tx_end;
    logic sync1, sync2, rx_in, rx_end, rx_par, rx_stop0, rx_pe, rx_odd, rx_st2;
    // divisor is re-latched only at wrap so a mid-period change cannot stretch the current tick
    assign s_tick = cnt == dvsr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            dvsr_q <= dvsr;
        end else if (s_tick) begin
            cnt    <= '0;
            dvsr_q <= dvsr;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end
    assign tx_end  = s_tick && tx_s == LAST;
    assign tx_busy = tx_state != IDLE;
    assign tx      = cfg_loopback | tx_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state     <= IDLE;
            tx_s         <= '0;
            tx_n         <= '0;
            tx_b         <= '0;
            tx_q         <= 1'b1;
            tx_par       <= 1'b0;
            tx_pe        <= 1'b0;
            tx_st2       <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            if (s_tick) tx_s <= tx_end ? '0 : tx_s + 5'd1;
            case (tx_state)
                IDLE: if (tx_start) begin
                    tx_state <= START;
                    tx_s     <= '0;
                    tx_b     <= din;
                    tx_q     <= 1'b0;
                    tx_par   <= ^din ^ cfg_par_odd;
                    tx_pe    <= cfg_par_en;
                    tx_st2   <= cfg_stop2;
                end
                START: if (tx_end) begin
                    tx_state <= DATA;
                    tx_n     <= '0;
                    tx_q     <= tx_b[0];
                end
                DATA: if (tx_end) begin
                    tx_b <= tx_b >> 1;
                    tx_n <= tx_n + 4'd1;
                    tx_q <= tx_b[1];
                    if (tx_n == NLAST) begin
                        tx_n     <= '0;
                        tx_state <= tx_pe ? PARITY : STOP;
                        tx_q     <= tx_pe ? tx_par : 1'b1;
                    end
                end
                PARITY: if (tx_end) begin
                    tx_state <= STOP;
                    tx_q     <= 1'b1;
                end
                STOP: if (tx_end) begin
                    if (tx_st2 && tx_n == 4'd0) begin
                        tx_n <= 4'd1;
                    end else begin
                        tx_state     <= IDLE;
                        tx_done_tick <= 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end
    assign rx_in   = cfg_loopback ? tx_q : sync2;
    assign rx_end  = s_tick && rx_s == LAST;
    assign rx_busy = rx_state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state     <= IDLE;
            rx_s         <= '0;
            rx_n         <= '0;
            rx_b         <= '0;
            rx_par       <= 1'b0;
            rx_stop0     <= 1'b1;
            rx_pe        <= 1'b0;
            rx_odd       <= 1'b0;
            rx_st2       <= 1'b0;
            rx_done_tick <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            if (s_tick) rx_s <= rx_end ? '0 : rx_s + 5'd1;
            case (rx_state)
                IDLE: if (!rx_in) begin
                    rx_state <= START;
                    rx_s     <= '0;
                    rx_pe    <= cfg_par_en;
                    rx_odd   <= cfg_par_odd;
                    rx_st2   <= cfg_stop2;
                end
                // mid-start resample; a high here means the low was a glitch
                START: if (s_tick && rx_s == HALF) begin
                    rx_s     <= '0;
                    rx_n     <= '0;
                    rx_state <= rx_in ? IDLE : DATA;
                end
                DATA: if (rx_end) begin
                    rx_b <= {rx_in, rx_b[DBIT-1:1]};
                    rx_n <= rx_n + 4'd1;
                    if (rx_n == NLAST) begin
                        rx_n     <= '0;
                        rx_state <= rx_pe ? PARITY : STOP;
                    end
                end
                PARITY: if (rx_end) begin
                    rx_par   <= rx_in;
                    rx_state <= STOP;
                end
                STOP: if (rx_end) begin
                    rx_stop0 <= rx_in;
                    if (rx_st2 && rx_n == 4'd0) begin
                        rx_n <= 4'd1;
                    end else begin
                        rx_state     <= IDLE;
                        rx_done_tick <= 1'b1;
                        dout         <= rx_b;
                        parity_err   <= rx_pe && (rx_par != (^rx_b ^ rx_odd));
                        frame_err    <= !(rx_st2 ? rx_stop0 : rx_in);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed checks of uart_cfg with dvsr=3 (one bit period = 64 clocks)
module tb_uart_cfg;
    logic clk = 1'b0, rst = 1'b1;
    logic [10:0] dvsr = 11'd3;
    logic pe = 1'b0, po = 1'b0, st2 = 1'b0, lb = 1'b0;
    logic [7:0] din = 8'h00;
    logic tx_start = 1'b0, rx = 1'b1;
    logic tx, tx_busy, rx_busy, tx_done_tick, rx_done_tick, parity_err, frame_err;
    logic [7:0] dout;
    int total = 0, bad = 0, tx_cnt = 0, rx_cnt = 0, tx_low = 0, busy_cyc = 0;
    int lat, bt, br, bl, bc;
    logic pb;
    uart_cfg dut (
        .clk(clk), .rst(rst), .dvsr(dvsr), .cfg_par_en(pe), .cfg_par_odd(po),
        .cfg_stop2(st2), .cfg_loopback(lb), .din(din), .tx_start(tx_start), .rx(rx),
        .tx(tx), .tx_busy(tx_busy), .rx_busy(rx_busy), .tx_done_tick(tx_done_tick),
        .rx_done_tick(rx_done_tick), .dout(dout), .parity_err(parity_err), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (tx_done_tick) tx_cnt++;
        if (rx_done_tick) rx_cnt++;
        if (lb && tx !== 1'b1) tx_low++;
        if (rx_busy) busy_cyc++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
    endtask
    // reset first so the baud phase is known: ticks land 4k clocks after reset release
    task automatic run_tx(input logic [7:0] d, output int l, output logic p);
        do_reset;
        din = d;
        clks(3);
        tx_start = 1'b1;
        clks(1);
        tx_start = 1'b0;
        l = 0;
        p = 1'bx;
        while (!tx_done_tick && l < 3000) begin
            clks(1);
            l++;
            if (l == 608) p = dut.tx_q;
        end
    endtask
    task automatic send_rx(input logic [7:0] d, input logic pen, input logic pv, input logic sv, input int stop_clks);
        rx = 1'b0;
        clks(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clks(64);
        end
        if (pen) begin
            rx = pv;
            clks(64);
        end
        rx = sv;
        clks(stop_clks);
        rx = 1'b1;
    endtask
    task automatic wait_rx(input int base, input string tag);
        int k = 0;
        while (rx_cnt == base && k < 3000) begin
            clks(1);
            k++;
        end
        chk(tag, rx_cnt - base, 1);
    endtask
    task automatic pulse_start(input logic [7:0] d);
        din = d;
        tx_start = 1'b1;
        clks(1);
        tx_start = 1'b0;
    endtask
    initial begin
        do_reset;
        chk("rst_tx", tx, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_busy", rx_busy, 0);
        chk("rst_dones", {tx_done_tick, rx_done_tick}, 0);
        chk("rst_dout", dout, 0);
        chk("rst_errs", {parity_err, frame_err}, 0);
        lb = 1'b1;
        br = rx_cnt;
        bl = tx_low;
        run_tx(8'hA5, lat, pb);
        chk("t1_lat", (lat >= 638 && lat <= 642) ? 640 : lat, 640);
        clks(50);
        wait_rx(br, "t1_rx_done");
        chk("t1_dout", dout, 8'hA5);
        chk("t1_errs", {parity_err, frame_err}, 0);
        chk("t1_tx_pin_high", tx_low - bl, 0);
        pe = 1'b1; po = 1'b1; st2 = 1'b1;
        br = rx_cnt;
        run_tx(8'h03, lat, pb);
        chk("t2_lat", (lat >= 766 && lat <= 770) ? 768 : lat, 768);
        chk("t2_par_bit", pb, 1);
        clks(50);
        wait_rx(br, "t2_rx_done");
        chk("t2_dout", dout, 8'h03);
        chk("t2_errs", {parity_err, frame_err}, 0);
        lb = 1'b0; pe = 1'b0; po = 1'b0; st2 = 1'b0;
        clks(200);
        br = rx_cnt;
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 48);
        clks(100);
        wait_rx(br, "t3_rx_done");
        chk("t3_dout", dout, 8'h5A);
        chk("t3_ferr", frame_err, 1);
        chk("t3_perr", parity_err, 0);
        br = rx_cnt;
        send_rx(8'hC3, 1'b0, 1'b0, 1'b1, 64);
        clks(50);
        wait_rx(br, "t3b_rx_done");
        chk("t3b_dout", dout, 8'hC3);
        chk("t3b_ferr", frame_err, 0);
        pe = 1'b1;
        br = rx_cnt;
        send_rx(8'h07, 1'b1, 1'b0, 1'b1, 64);
        clks(50);
        wait_rx(br, "tp_rx_done");
        chk("tp_dout", dout, 8'h07);
        chk("tp_errs", {parity_err, frame_err}, 2'b10);
        pe = 1'b0;
        clks(100);
        br = rx_cnt;
        bc = busy_cyc;
        rx = 1'b0;
        clks(12);
        rx = 1'b1;
        clks(300);
        chk("t4_no_done", rx_cnt - br, 0);
        chk("t4_busy_seen", busy_cyc > bc, 1);
        chk("t4_rx_busy", rx_busy, 0);
        chk("t4_status", {dout, parity_err, frame_err}, {8'h07, 2'b10});
        lb = 1'b1;
        bt = tx_cnt;
        br = rx_cnt;
        pulse_start(8'h11);
        clks(200);
        pulse_start(8'h22);
        clks(900);
        chk("t5_tx_dones", tx_cnt - bt, 1);
        chk("t5_rx_dones", rx_cnt - br, 1);
        chk("t5_dout", dout, 8'h11);
        bt = tx_cnt;
        br = rx_cnt;
        pulse_start(8'h77);
        clks(300);
        rst = 1'b1;
        clks(1);
        chk("t6_tx", tx, 1);
        chk("t6_busy", {tx_busy, rx_busy}, 0);
        chk("t6_dout", dout, 0);
        rst = 1'b0;
        clks(800);
        chk("t6_no_tx_done", tx_cnt - bt, 0);
        chk("t6_no_rx_done", rx_cnt - br, 0);
        bt = tx_cnt;
        br = rx_cnt;
        pulse_start(8'h3C);
        clks(900);
        chk("t6_tx_done", tx_cnt - bt, 1);
        chk("t6_rx_done", rx_cnt - br, 1);
        chk("t6_dout2", dout, 8'h3C);
        chk("t6_errs", {parity_err, frame_err}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
